// File: rtl/tdest_merge_if.sv
// rtl/tdest_merge_if.sv - stream bundle shared by the merge inputs and output
interface tdest_merge_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
    logic [31:0]           tdest;

    // Inputs carry no routing tag; only the merged output drives tdest.
    modport master (output tvalid, output tlast, output tdata, output tdest, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/tdest_merge.sv
// rtl/tdest_merge.sv - packet-level 2:1 stream merger tagging each beat with its source
module tdest_merge #(
    parameter int DATA_WIDTH = 32,
    parameter bit STRICT     = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    tdest_merge_if.slave  s0,
    tdest_merge_if.slave  s1,
    tdest_merge_if.master m0,
    output logic [31:0]   pkt_count
);
    typedef enum logic {
        ST_BOUNDARY = 1'b0,
        ST_IN_PKT   = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   pref_q, pref_d;
    logic   owner_q, owner_d;
    logic   grant;

    logic                  can_load;
    logic                  accept;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] beat_data;

    logic                  out_valid;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_src;

    assign can_load  = !out_valid || m0.tready;
    assign s0.tready = can_load && !grant && !reset;
    assign s1.tready = can_load &&  grant && !reset;
    assign accept    = grant ? (s1.tvalid && s1.tready) : (s0.tvalid && s0.tready);
    assign beat_data = grant ? s1.tdata : s0.tdata;
    assign beat_last = grant ? s1.tlast : s0.tlast;

    // Mid-packet the owner is locked; at a boundary the preferred source
    // wins, and the work-conserving variant falls over to the other one.
    always_comb begin
        grant = pref_q;
        if (state_q == ST_IN_PKT) begin
            grant = owner_q;
        end else if (!STRICT) begin
            if (pref_q ? s1.tvalid : s0.tvalid) begin
                grant = pref_q;
            end else if (pref_q ? s0.tvalid : s1.tvalid) begin
                grant = !pref_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pref_d  = pref_q;
        owner_d = owner_q;
        if (accept) begin
            if (beat_last) begin
                state_d = ST_BOUNDARY;
                pref_d  = !grant;
            end else begin
                state_d = ST_IN_PKT;
                owner_d = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOUNDARY;
            pref_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pref_q  <= pref_d;
            owner_q <= owner_d;
        end
    end

    // Data/last/tag hold their last value after the beat drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_last  <= beat_last;
                out_data  <= beat_data;
                out_src   <= grant;
            end else if (m0.tready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && m0.tready && out_last) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

    assign m0.tvalid = out_valid;
    assign m0.tlast  = out_last;
    assign m0.tdata  = out_data;
    assign m0.tdest  = {31'd0, out_src};
endmodule

// File: tb/tb_tdest_merge.sv
// tb/tb_tdest_merge.sv - directed vector bench for tdest_merge (strict and work-conserving)
module tb_tdest_merge;
    logic clk = 1'b0;
    logic reset;
    logic [31:0] pkt_count;
    logic [31:0] pkt_count_ws;

    always #5 clk = ~clk;

    tdest_merge_if #(.DATA_WIDTH(32)) s0_if ();
    tdest_merge_if #(.DATA_WIDTH(32)) s1_if ();
    tdest_merge_if #(.DATA_WIDTH(32)) m0_if ();
    tdest_merge_if #(.DATA_WIDTH(32)) w0_if ();
    tdest_merge_if #(.DATA_WIDTH(32)) w1_if ();
    tdest_merge_if #(.DATA_WIDTH(32)) wm_if ();

    tdest_merge #(.DATA_WIDTH(32), .STRICT(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .s0        (s0_if.slave),
        .s1        (s1_if.slave),
        .m0        (m0_if.master),
        .pkt_count (pkt_count)
    );

    tdest_merge #(.DATA_WIDTH(32), .STRICT(1'b0)) dut_ws (
        .clk       (clk),
        .reset     (reset),
        .s0        (w0_if.slave),
        .s1        (w1_if.slave),
        .m0        (wm_if.master),
        .pkt_count (pkt_count_ws)
    );

    typedef struct {
        logic        rst;
        logic        v0, l0;
        logic [31:0] d0;
        logic        v1, l1;
        logic [31:0] d1;
        logic        rdy;
        logic        r0, r1, mv, ml;
        logic [31:0] md;
        logic        dst;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic rst, input logic v0, input logic l0, input logic [31:0] d0,
                       input logic v1, input logic l1, input logic [31:0] d1, input logic rdy,
                       input logic r0, input logic r1, input logic mv, input logic ml,
                       input logic [31:0] md, input logic dst, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.l0 = l0; v.d0 = d0;
        v.v1 = v1; v.l1 = l1; v.d1 = d1; v.rdy = rdy;
        v.r0 = r0; v.r1 = r1; v.mv = mv; v.ml = ml;
        v.md = md; v.dst = dst; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        logic [99:0] got_row, exp_row;

        reset = 1'b1;
        s0_if.tvalid = 0; s0_if.tlast = 0; s0_if.tdata = '0; s0_if.tdest = '0;
        s1_if.tvalid = 0; s1_if.tlast = 0; s1_if.tdata = '0; s1_if.tdest = '0;
        w0_if.tvalid = 0; w0_if.tlast = 0; w0_if.tdata = '0; w0_if.tdest = '0;
        w1_if.tvalid = 0; w1_if.tlast = 0; w1_if.tdata = '0; w1_if.tdest = '0;
        m0_if.tready = 1'b1;
        wm_if.tready = 1'b1;

        // rst v0 l0 d0     v1 l1 d1     rdy | r0 r1 mv ml md    dst cnt
        add(1, 0,0,32'h00,  0,0,32'h00,  1,    0,0,0,0,32'h00, 0,0);
        // concurrent packets: A0..A2 from s0, B0..B1 from s1
        add(0, 1,0,32'hA0,  1,0,32'hB0,  1,    1,0,0,0,32'h00, 0,0);
        add(0, 1,0,32'hA1,  1,0,32'hB0,  1,    1,0,1,0,32'hA0, 0,0);
        add(0, 1,1,32'hA2,  1,0,32'hB0,  1,    1,0,1,0,32'hA1, 0,0);
        add(0, 0,0,32'h00,  1,0,32'hB0,  1,    0,1,1,1,32'hA2, 0,0);
        add(0, 0,0,32'h00,  1,1,32'hB1,  1,    0,1,1,0,32'hB0, 1,1);
        add(0, 0,0,32'h00,  0,0,32'h00,  1,    1,0,1,1,32'hB1, 1,1);
        add(0, 0,0,32'h00,  0,0,32'h00,  1,    1,0,0,1,32'hB1, 1,2);
        // strict: idle s0 keeps the grant, s1 starves
        for (int i = 0; i < 10; i++)
            add(0, 0,0,32'h00, 1,1,32'hC0, 1,  1,0,0,1,32'hB1, 1,2);
        add(0, 1,1,32'h11,  1,1,32'hC0,  1,    1,0,0,1,32'hB1, 1,2);
        add(0, 0,0,32'h00,  1,1,32'hC0,  1,    0,1,1,1,32'h11, 0,2);
        add(0, 0,0,32'h00,  0,0,32'h00,  1,    1,0,1,1,32'hC0, 1,3);
        add(0, 0,0,32'h00,  0,0,32'h00,  1,    1,0,0,1,32'hC0, 1,4);
        // backpressure during a 4-beat s0 packet, s1 waiting
        add(0, 1,0,32'hD0,  1,1,32'hE0,  1,    1,0,0,1,32'hC0, 1,4);
        add(0, 1,0,32'hD1,  1,1,32'hE0,  0,    0,0,1,0,32'hD0, 0,4);
        add(0, 1,0,32'hD1,  1,1,32'hE0,  0,    0,0,1,0,32'hD0, 0,4);
        add(0, 1,0,32'hD1,  1,1,32'hE0,  1,    1,0,1,0,32'hD0, 0,4);
        add(0, 1,0,32'hD2,  1,1,32'hE0,  1,    1,0,1,0,32'hD1, 0,4);
        add(0, 1,1,32'hD3,  1,1,32'hE0,  0,    0,0,1,0,32'hD2, 0,4);
        add(0, 1,1,32'hD3,  1,1,32'hE0,  1,    1,0,1,0,32'hD2, 0,4);
        add(0, 0,0,32'h00,  1,1,32'hE0,  1,    0,1,1,1,32'hD3, 0,4);
        add(0, 0,0,32'h00,  0,0,32'h00,  0,    0,0,1,1,32'hE0, 1,5);
        add(0, 0,0,32'h00,  0,0,32'h00,  1,    1,0,1,1,32'hE0, 1,5);
        add(0, 0,0,32'h00,  0,0,32'h00,  1,    1,0,0,1,32'hE0, 1,6);
        // reset in the middle of an s1 packet
        add(0, 1,1,32'hF0,  1,0,32'h60,  1,    1,0,0,1,32'hE0, 1,6);
        add(0, 0,0,32'h00,  1,0,32'h60,  1,    0,1,1,1,32'hF0, 0,6);
        add(0, 1,1,32'h70,  1,0,32'h61,  1,    0,1,1,0,32'h60, 1,7);
        add(1, 1,1,32'h70,  1,0,32'h62,  1,    0,0,1,0,32'h61, 1,7);
        add(0, 1,1,32'h70,  1,1,32'h60,  1,    1,0,0,0,32'h00, 0,0);
        add(0, 0,0,32'h00,  1,1,32'h60,  1,    0,1,1,1,32'h70, 0,0);
        add(0, 0,0,32'h00,  0,0,32'h00,  1,    1,0,1,1,32'h60, 1,1);
        add(0, 0,0,32'h00,  0,0,32'h00,  1,    1,0,0,1,32'h60, 1,2);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset        = vecs[i].rst;
            s0_if.tvalid = vecs[i].v0; s0_if.tlast = vecs[i].l0; s0_if.tdata = vecs[i].d0;
            s1_if.tvalid = vecs[i].v1; s1_if.tlast = vecs[i].l1; s1_if.tdata = vecs[i].d1;
            m0_if.tready = vecs[i].rdy;
            #1;
            got_row = {s0_if.tready, s1_if.tready, m0_if.tvalid, m0_if.tlast,
                       m0_if.tdata, m0_if.tdest, pkt_count};
            exp_row = {vecs[i].r0, vecs[i].r1, vecs[i].mv, vecs[i].ml,
                       vecs[i].md, {31'd0, vecs[i].dst}, vecs[i].cnt};
            checks++;
            if (got_row !== exp_row) begin
                errors++;
                $display("FAIL row %0d: got rdy0=%b rdy1=%b v=%b l=%b d=%h dest=%h cnt=%0d expected rdy0=%b rdy1=%b v=%b l=%b d=%h dest=%h cnt=%0d",
                         i, s0_if.tready, s1_if.tready, m0_if.tvalid, m0_if.tlast, m0_if.tdata,
                         m0_if.tdest, pkt_count, vecs[i].r0, vecs[i].r1, vecs[i].mv, vecs[i].ml,
                         vecs[i].md, {31'd0, vecs[i].dst}, vecs[i].cnt);
            end
        end

        // packet counter wrap
        @(negedge clk);
        s0_if.tvalid = 0; s1_if.tvalid = 0; m0_if.tready = 1;
        force dut.pkt_count = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count;
        #1;
        check("wrap_preset", pkt_count, 32'hFFFF_FFFF);
        @(negedge clk);
        s0_if.tvalid = 1; s0_if.tlast = 1; s0_if.tdata = 32'h77;
        @(negedge clk);
        s0_if.tvalid = 0;
        #1;
        check("wrap_beat_data", m0_if.tdata, 32'h77);
        check("wrap_beat_valid", {31'd0, m0_if.tvalid}, 32'd1);
        @(negedge clk);
        #1;
        check("wrap_count", pkt_count, 32'd0);

        // work-conserving arbitration
        @(negedge clk);
        w1_if.tvalid = 1; w1_if.tlast = 1; w1_if.tdata = 32'hC5;
        #1;
        check("ws_idle_s0_rdy1", {30'd0, w0_if.tready, w1_if.tready}, 32'd1);
        @(negedge clk);
        w1_if.tvalid = 0;
        #1;
        check("ws_first_data", wm_if.tdata, 32'hC5);
        check("ws_first_dest", wm_if.tdest, 32'd1);
        @(negedge clk);
        w0_if.tvalid = 1; w0_if.tlast = 1; w0_if.tdata = 32'h50;
        w1_if.tvalid = 1; w1_if.tlast = 1; w1_if.tdata = 32'h51;
        #1;
        check("ws_pref_back_to_s0", {30'd0, w0_if.tready, w1_if.tready}, 32'd2);
        @(negedge clk);
        w0_if.tvalid = 0;
        #1;
        check("ws_s0_data", {wm_if.tdata[30:0], wm_if.tdest[0]}, {31'h50, 1'b0});
        check("ws_s1_rdy", {30'd0, w0_if.tready, w1_if.tready}, 32'd1);
        @(negedge clk);
        w1_if.tvalid = 0;
        #1;
        check("ws_s1_data", {wm_if.tdata[30:0], wm_if.tdest[0]}, {31'h51, 1'b1});
        @(negedge clk);
        #1;
        check("ws_count", pkt_count_ws, 32'd3);
        check("ws_drained", {31'd0, wm_if.tvalid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
